drive_seq_ctrl: RTL
===================

Name: drive_seq_ctrl

Overview:
- Per-period parameter scheduler for the transducer PWM datapath.
- On each ultrasound period start it walks all DEPTH transducers and fetches packed duty/phase words from a two-segment BRAM.
- It writes one transducer entry per cycle into the duty/phase register arrays that feed the silent LPF and PWM generators.
- It handles host segment swaps at period boundaries only, so a period never mixes old and new patterns.

Parameters:
- DEPTH, 249, number of transducers, i.e. entries walked per period.
- WIDTH, 13, duty/phase/cycle width in bits.
- ADDR_W, 8, transducer index width; must satisfy 2**ADDR_W >= DEPTH.
- RD_LAT, 2, BRAM read latency in CLK cycles; legal range 1..4.

Ports:
- CLK  in  1  200 MHz ultrasound clock.
- RESET_N  in  1  synchronous, active-low reset.
- START  in  1  one-cycle pulse at time count 0 (period start).
- ENABLE  in  1  sequencing enable, sampled at START.
- SEG_REQ  in  1  one-cycle pulse: host committed a segment change.
- SEG_SEL  in  1  target segment, sampled with SEG_REQ.
- MAX_DUTY  in  WIDTH  duty clamp ceiling.
- BRAM_EN  out  1  read enable.
- BRAM_ADDR  out  ADDR_W+1  {segment, index}.
- BRAM_DOUT  in  2*WIDTH  {duty[2W-1:W], phase[W-1:0]}.
- WR_EN  out  1  array write strobe.
- WR_IDX  out  ADDR_W  array index.
- DUTY_OUT  out  WIDTH  duty value to write.
- PHASE_OUT  out  WIDTH  phase value to write.
- ACT_SEG  out  1  segment currently in use.
- BUSY  out  1  walk in progress.
- DONE  out  1  one-cycle pulse when the last write is issued.
- OVERRUN  out  1  one-cycle pulse when START arrives while BUSY.

Behaviour:
- Reset: all outputs 0; state IDLE; ACT_SEG=0; pending request cleared. A reset mid-walk aborts immediately, and no further WR_EN is issued.
- Pending swap:
  - SEG_REQ sets pend=1 and pend_seg=SEG_SEL.
  - A later SEG_REQ before a START overwrites pend_seg.
  - SEG_REQ coincident with START is held for the next START; it is not applied this period.
- FSM IDLE:
  - On START & ENABLE: if pend, ACT_SEG<=pend_seg and pend<=0. Then idx<=0, BUSY<=1, go FETCH.
  - On START & !ENABLE: stay IDLE. The pending swap is still applied.
- FSM FETCH:
  - Each cycle drive BRAM_EN=1 and BRAM_ADDR={ACT_SEG, idx}; idx++.
  - After issuing idx=DEPTH-1, go DRAIN.
- FSM DRAIN:
  - Wait until the read-valid pipe is empty, then go IDLE with BUSY<=0.
- Write path:
  - A valid shift register of length RD_LAT carries the index alongside each read.
  - WR_EN is asserted exactly RD_LAT+1 cycles after the matching BRAM_EN (BRAM latency plus one output register).
  - Writes are contiguous: DEPTH consecutive WR_EN cycles, WR_IDX runs 0..DEPTH-1.
- DONE pulses on the same cycle as the WR_EN with WR_IDX=DEPTH-1.
- Arithmetic:
  - DUTY_OUT = min(duty, MAX_DUTY), unsigned compare.
  - PHASE_OUT = phase, passed through unmodified.
  - DUTY_OUT and PHASE_OUT hold their last values when WR_EN=0.
- START while BUSY: ignored; OVERRUN pulses; the walk continues unchanged.
- Walk length is DEPTH+RD_LAT+1 cycles, which must stay below the period (5000 cycles nominal). OVERRUN therefore flags misconfiguration only.
- The ENABLE drop mid-walk is ignored until the next START.

Optional Feature:
- Macro DRIVE_SEQ_FORCE_STOP_EN.
- Defined: adds input port STOP (1 bit).
  - While STOP=1 at a write cycle, DUTY_OUT is forced to 0. PHASE_OUT passes through.
  - The walk still runs on every START, regardless of ENABLE, so all transducers are silenced within one period.
- Not defined: the STOP port is absent and the behaviour is exactly as above.

Decomposition:
- Package drive_seq_pkg holds:
  - state_t enum {IDLE, FETCH, DRAIN};
  - the packed-word field slice localparams (DUTY_MSB/LSB, PHASE_MSB/LSB);
  - the default WIDTH/DEPTH constants shared with the top level.
- One sub-module, drive_seq_rd_pipe: a parameterised RD_LAT-deep valid/index shift register with synchronous active-low reset.

Test Plan:
- BRAM seg0 word i = {i, 2*i}, MAX_DUTY=8191, ENABLE=1, single START -> WR_EN high for 249 consecutive cycles starting RD_LAT+1 after the first BRAM_EN; WR_IDX 0..248; DUTY_OUT=i, PHASE_OUT=2i; DONE coincides with WR_IDX=248.
- Clamp: seg0 duty=3000 for all entries, MAX_DUTY=2500 -> every DUTY_OUT=2500, phase unchanged.
- SEG_REQ(SEG_SEL=1) mid-walk, second START -> current walk uses seg 0 addresses (bit ADDR_W=0); next walk uses BRAM_ADDR[8]=1 and ACT_SEG=1. SEG_REQ on the same cycle as START -> swap deferred one period.
- START pulsed again 100 cycles into a walk -> OVERRUN=1 for one cycle; WR_IDX sequence unbroken through 248; no second walk starts.
- RESET_N=0 for one cycle at write index 120 -> BUSY/WR_EN/ACT_SEG=0 next cycle; no writes until the next START; the next walk starts at idx 0.
- DRIVE_SEQ_FORCE_STOP_EN defined, STOP=1, ENABLE=0, START -> 249 writes, all with DUTY_OUT=0.

Source files
------------

// File: rtl/drive_seq_pkg.sv
`default_nettype none
// ============================================================================
// drive_seq_pkg : shared constants, packed-word layout and FSM state type
// Rev 1.0
// ============================================================================
package drive_seq_pkg;

  localparam int DEFAULT_DEPTH  = 249;
  localparam int DEFAULT_WIDTH  = 13;
  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_RD_LAT = 2;

  // BRAM word layout: {duty, phase}
  localparam int DUTY_MSB  = 2 * DEFAULT_WIDTH - 1;
  localparam int DUTY_LSB  = DEFAULT_WIDTH;
  localparam int PHASE_MSB = DEFAULT_WIDTH - 1;
  localparam int PHASE_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/drive_seq_rd_pipe.sv
`default_nettype none
// ============================================================================
// drive_seq_rd_pipe : RD_LAT-deep valid/index shift register tracking reads
// Rev 1.0
// ============================================================================
module drive_seq_rd_pipe #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_idx,
  output logic              o_vld,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_busy
);

  logic [RD_LAT-1:0]             vld_q;
  logic [RD_LAT-1:0]             vld_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] idx_q;
  logic [RD_LAT-1:0][ADDR_W-1:0] idx_d;

  always_comb begin
    vld_d    = vld_q;
    idx_d    = idx_q;
    vld_d[0] = i_vld;
    idx_d[0] = i_idx;
    for (int s = 1; s < RD_LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      idx_d[s] = idx_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  assign o_vld  = vld_q[RD_LAT-1];
  assign o_idx  = idx_q[RD_LAT-1];
  assign o_busy = |vld_q;

endmodule
`default_nettype wire

// File: rtl/drive_seq_ctrl.sv
`default_nettype none
// ============================================================================
// drive_seq_ctrl : per-period duty/phase walk from a two-segment BRAM into
// the transducer register arrays. Optional STOP input: DRIVE_SEQ_FORCE_STOP_EN.
// Rev 1.0
// ============================================================================
module drive_seq_ctrl
  import drive_seq_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int RD_LAT = DEFAULT_RD_LAT
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic               ENABLE,
  input  logic               SEG_REQ,
  input  logic               SEG_SEL,
  input  logic [WIDTH-1:0]   MAX_DUTY,
  output logic               BRAM_EN,
  output logic [ADDR_W:0]    BRAM_ADDR,
  input  logic [2*WIDTH-1:0] BRAM_DOUT,
  output logic               WR_EN,
  output logic [ADDR_W-1:0]  WR_IDX,
  output logic [WIDTH-1:0]   DUTY_OUT,
  output logic [WIDTH-1:0]   PHASE_OUT,
  output logic               ACT_SEG,
  output logic               BUSY,
  output logic               DONE,
  output logic               OVERRUN
`ifdef DRIVE_SEQ_FORCE_STOP_EN
  ,
  input  logic               STOP
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              act_seg_q, act_seg_d;
  logic              pend_q, pend_d;
  logic              pend_seg_q, pend_seg_d;
  logic              overrun_q, overrun_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic [WIDTH-1:0]  duty_q, duty_d;
  logic [WIDTH-1:0]  phase_q, phase_d;
  logic              done_q, done_d;

  logic              fetch;
  logic              launch;
  logic              force_stop;
  logic              pipe_vld;
  logic [ADDR_W-1:0] pipe_idx;
  logic              pipe_busy;
  logic [WIDTH-1:0]  duty_raw;
  logic [WIDTH-1:0]  duty_clamped;

`ifdef DRIVE_SEQ_FORCE_STOP_EN
  assign force_stop = STOP;
`else
  assign force_stop = 1'b0;
`endif

  // A forced stop must still sweep every entry so all outputs get silenced
  assign launch = START && (ENABLE || force_stop);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    act_seg_d  = act_seg_q;
    pend_d     = pend_q;
    pend_seg_d = pend_seg_q;
    overrun_d  = 1'b0;
    fetch      = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          if (pend_q) begin
            act_seg_d = pend_seg_q;
            pend_d    = 1'b0;
          end
          if (launch) begin
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        fetch = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pipe_busy) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (START && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    // Placed last so a request coincident with START survives for the next period
    if (SEG_REQ) begin
      pend_d     = 1'b1;
      pend_seg_d = SEG_SEL;
    end
  end

  drive_seq_rd_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_rd_pipe (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .i_vld  (fetch),
    .i_idx  (idx_q),
    .o_vld  (pipe_vld),
    .o_idx  (pipe_idx),
    .o_busy (pipe_busy)
  );

  assign duty_raw     = BRAM_DOUT[DUTY_MSB:DUTY_LSB];
  assign duty_clamped = (duty_raw > MAX_DUTY) ? MAX_DUTY : duty_raw;

  always_comb begin
    wr_en_d  = pipe_vld;
    wr_idx_d = wr_idx_q;
    duty_d   = duty_q;
    phase_d  = phase_q;
    done_d   = 1'b0;
    if (pipe_vld) begin
      wr_idx_d = pipe_idx;
      duty_d   = force_stop ? '0 : duty_clamped;
      phase_d  = BRAM_DOUT[PHASE_MSB:PHASE_LSB];
      done_d   = (pipe_idx == LAST_IDX);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      act_seg_q  <= 1'b0;
      pend_q     <= 1'b0;
      pend_seg_q <= 1'b0;
      overrun_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      duty_q     <= '0;
      phase_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      act_seg_q  <= act_seg_d;
      pend_q     <= pend_d;
      pend_seg_q <= pend_seg_d;
      overrun_q  <= overrun_d;
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      duty_q     <= duty_d;
      phase_q    <= phase_d;
      done_q     <= done_d;
    end
  end

  assign BRAM_EN   = fetch;
  assign BRAM_ADDR = fetch ? {act_seg_q, idx_q} : '0;
  assign WR_EN     = wr_en_q;
  assign WR_IDX    = wr_idx_q;
  assign DUTY_OUT  = duty_q;
  assign PHASE_OUT = phase_q;
  assign ACT_SEG   = act_seg_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign OVERRUN   = overrun_q;

endmodule
`default_nettype wire
